// File: rtl/fbuf_arbiter_if.sv
// CPU word/sprite port of the framebuffer arbiter.
// The CPU side (master) raises cpu_req with the operation fields and holds
// them until the arbiter (slave) answers with a one-cycle cpu_ack.
interface fbuf_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_xor;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_collision;

    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_xor,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_ack,
        input  cpu_rdata,
        input  cpu_collision
    );

    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_xor,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_ack,
        output cpu_rdata,
        output cpu_collision
    );
endinterface

// File: rtl/fbuf_arbiter.sv
// Framebuffer RAM arbiter: shares one single-port synchronous RAM between
// display scanout (highest priority), a clear-screen engine and the CPU port.
// CPU XOR writes run as read-modify-write and report the Chip-8 collision flag.
// Optional build macro FBUF_STALL_COUNT_EN adds the stall_cycles counter port.
module fbuf_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int CLEAR_WORDS = 512
) (
    input  logic              clk,
    input  logic              res,
    input  logic              disp_active,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              clr_req,
    output logic              clr_busy,
    fbuf_arbiter_if.slave     cpu,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef FBUF_STALL_COUNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    // One extra bit so the clear counter can never wrap back to word 0.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_ACK,
        S_CLR
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [CNT_W-1:0]  clr_cnt;
    logic              clr_pending;
    logic              xor_op;
    logic [DATA_W-1:0] wr_word_p1;
    logic              coll_p1;
    logic [DATA_W-1:0] rdata_q;
    logic              collision_q;
    logic              disp_vld_p1;
    logic [DATA_W-1:0] disp_hold_p1;

    logic              needs_bus;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic              clr_last;

`ifdef FBUF_STALL_COUNT_EN
    logic              stall;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    assign clr_last = (clr_cnt == CNT_LAST);

    // Next-state decode and the engine-side RAM request for the current state.
    always_comb begin
        state_nx  = state;
        needs_bus = 1'b0;
        bus_addr  = '0;
        bus_we    = 1'b0;
        bus_wdata = '0;
        case (state)
            S_IDLE: begin
                // A clear always goes ahead of a CPU request arriving with it.
                if (clr_pending || clr_req) begin
                    state_nx = S_CLR;
                end else if (cpu.cpu_req) begin
                    if (!cpu.cpu_we || cpu.cpu_xor) begin
                        state_nx = S_RD;
                    end else begin
                        state_nx = S_WR;
                    end
                end
            end
            S_RD: begin
                needs_bus = 1'b1;
                bus_addr  = cpu.cpu_addr;
                if (!disp_active) begin
                    state_nx = S_CAP;
                end
            end
            S_CAP: begin
                state_nx = xor_op ? S_WR : S_ACK;
            end
            S_WR: begin
                needs_bus = 1'b1;
                bus_addr  = cpu.cpu_addr;
                bus_we    = 1'b1;
                bus_wdata = xor_op ? wr_word_p1 : cpu.cpu_wdata;
                if (!disp_active) begin
                    state_nx = S_ACK;
                end
            end
            S_ACK: begin
                state_nx = S_IDLE;
            end
            S_CLR: begin
                needs_bus = 1'b1;
                bus_addr  = clr_cnt[ADDR_W-1:0];
                bus_we    = 1'b1;
                bus_wdata = '0;
                // A fresh clr_req on the last word restarts the sweep instead.
                if (!disp_active && clr_last && !clr_req) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // RAM port mux: the display owns the port outright whenever it is active.
    always_comb begin
        ram_addr  = bus_addr;
        ram_we    = bus_we;
        ram_wdata = bus_wdata;
        if (disp_active) begin
            ram_addr  = disp_addr;
            ram_we    = 1'b0;
            ram_wdata = '0;
        end
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Clear engine bookkeeping: pending flag and word counter.
    always_ff @(posedge clk) begin
        if (res) begin
            clr_pending <= 1'b0;
            clr_cnt     <= '0;
        end else if (clr_req) begin
            clr_pending <= 1'b1;
            clr_cnt     <= '0;
        end else if (state == S_CLR && !disp_active) begin
            if (clr_last) begin
                clr_pending <= 1'b0;
                clr_cnt     <= '0;
            end else begin
                clr_cnt <= clr_cnt + CNT_W'(1);
            end
        end
    end

    assign clr_busy = clr_pending;

    // Latch the kind of CPU operation while the request is being accepted.
    always_ff @(posedge clk) begin
        if (res) begin
            xor_op <= 1'b0;
        end else if (state == S_IDLE) begin
            xor_op <= cpu.cpu_we & cpu.cpu_xor;
        end
    end

    // --- stage p1: old word from RAM is available in CAP ---
    // Merge the XOR mask into the old word and precompute the collision bit.
    always_ff @(posedge clk) begin
        if (state == S_CAP) begin
            wr_word_p1 <= ram_rdata ^ cpu.cpu_wdata;
            coll_p1    <= |(ram_rdata & cpu.cpu_wdata);
        end
    end

    // CPU-visible results: read data in CAP, collision when an XOR write lands.
    always_ff @(posedge clk) begin
        if (res) begin
            rdata_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            if (state == S_CAP) begin
                rdata_q <= ram_rdata;
            end
            if (state == S_WR && !disp_active && xor_op) begin
                collision_q <= coll_p1;
            end
        end
    end

    assign cpu.cpu_ack       = (state == S_ACK);
    assign cpu.cpu_rdata     = rdata_q;
    assign cpu.cpu_collision = collision_q;

    // --- stage p1: display read data returns one cycle after its address ---
    // Track display ownership and keep the last word it fetched.
    always_ff @(posedge clk) begin
        if (res) begin
            disp_vld_p1  <= 1'b0;
            disp_hold_p1 <= '0;
        end else begin
            disp_vld_p1 <= disp_active;
            if (disp_vld_p1) begin
                disp_hold_p1 <= ram_rdata;
            end
        end
    end

    // Pass RAM data straight through so display latency equals raw RAM latency.
    assign disp_data = disp_vld_p1 ? ram_rdata : disp_hold_p1;

`ifdef FBUF_STALL_COUNT_EN
    assign stall = needs_bus && disp_active;

    // Count cycles an engine waits for the display; saturates, restarts per clear.
    always_ff @(posedge clk) begin
        if (res || clr_req) begin
            stall_cycles <= '0;
        end else if (stall) begin
            stall_cycles <= sat_inc16(stall_cycles);
        end
    end
`else
    // Without the stall counter the bus-request flag has no consumer.
    logic unused_needs_bus;
    assign unused_needs_bus = needs_bus;
`endif

endmodule
